// File: rtl/jtag_dm_pkg.sv
// Shared debug-module definitions: DM register addresses, SBCS field positions
// and DMI operation encodings.
package jtag_dm_pkg;

    localparam logic [6:0] DM_SBCS       = 7'h38;
    localparam logic [6:0] DM_SBADDRESS0 = 7'h39;
    localparam logic [6:0] DM_SBDATA0    = 7'h3C;

    localparam int SBCS_VERSION_LSB = 29;
    localparam int SBCS_BUSYERROR   = 22;
    localparam int SBCS_BUSY        = 21;
    localparam int SBCS_READONADDR  = 20;
    localparam int SBCS_ACCESS_LSB  = 17;
    localparam int SBCS_AUTOINC     = 16;
    localparam int SBCS_READONDATA  = 15;
    localparam int SBCS_ERROR_LSB   = 12;
    localparam int SBCS_ASIZE_LSB   = 5;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2
    } dmi_op_e;

endpackage

// File: rtl/jtag_sb_csr.sv
// System-bus CSR front end: decodes DMI accesses to SBCS/SBADDRESS0/SBDATA0,
// holds the sb* state and issues start pulses to the system-bus engine.
module jtag_sb_csr
    import jtag_dm_pkg::*;
#(
    parameter int SBASIZE   = 32,
    parameter int SBVERSION = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    input  logic [6:0]  dmi_addr_i,
    input  logic [1:0]  dmi_op_i,
    input  logic [31:0] dmi_data_i,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic [31:0] dmi_resp_data_o,
    output logic [31:0] sbaddress_o,
    output logic        sbaddress_write_valid_o,
    output logic        sbreadonaddr_o,
    output logic        sbautoincrement_o,
    output logic [2:0]  sbaccess_o,
    output logic        sbreadondata_o,
    output logic [31:0] sbdata_o,
    output logic        sbdata_read_valid_o,
    output logic        sbdata_write_valid_o,
    input  logic [31:0] sbaddress_i,
    input  logic [31:0] sbdata_i,
    input  logic        sbdata_valid_i,
    input  logic        sbbusy_i,
    input  logic [2:0]  sberror_i
);

    localparam logic [2:0] LP_VERSION = 3'(SBVERSION);
    localparam logic [6:0] LP_ASIZE   = 7'(SBASIZE);

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_sbbusyerror;
    logic [2:0]  r_sberror;
    logic        r_readonaddr;
    logic        r_autoinc;
    logic        r_readondata;
    logic [2:0]  r_access;
    logic [31:0] r_sbaddress;
    logic [31:0] r_sbdata;
    logic        r_addr_wr_pls;
    logic        r_data_wr_pls;
    logic        r_data_rd_pls;
    logic        r_last_read;

    logic        w_accept;
    logic        w_sbcs_wr;
    logic        w_addr_wr;
    logic        w_data_wr;
    logic        w_data_rd;
    logic        w_busy_hit;
    logic        w_blocked;
    logic [31:0] w_sbcs;
    logic [31:0] w_rdata;
    logic [2:0]  w_sberror_nxt;

    assign w_accept   = dmi_req_valid_i && r_req_ready;
    assign w_sbcs_wr  = w_accept && (dmi_op_i == DMI_WRITE) && (dmi_addr_i == DM_SBCS);
    assign w_addr_wr  = w_accept && (dmi_op_i == DMI_WRITE) && (dmi_addr_i == DM_SBADDRESS0);
    assign w_data_wr  = w_accept && (dmi_op_i == DMI_WRITE) && (dmi_addr_i == DM_SBDATA0);
    assign w_data_rd  = w_accept && (dmi_op_i == DMI_READ)  && (dmi_addr_i == DM_SBDATA0);
    assign w_busy_hit = sbbusy_i && (w_addr_wr || w_data_wr || w_data_rd);
    assign w_blocked  = sbbusy_i || r_sbbusyerror || (r_sberror != 3'd0);

    // Only 8/16/32-bit accesses are supported by the engine.
    assign w_sbcs = {LP_VERSION, 6'b0, r_sbbusyerror, sbbusy_i, r_readonaddr, r_access,
                     r_autoinc, r_readondata, r_sberror, LP_ASIZE, 2'b0, 3'b111};

    always_comb begin
        w_rdata = '0;
        if (dmi_op_i == DMI_READ) begin
            case (dmi_addr_i)
                DM_SBCS:       w_rdata = w_sbcs;
                DM_SBADDRESS0: w_rdata = r_sbaddress;
                DM_SBDATA0:    w_rdata = r_sbdata;
                default:       w_rdata = '0;
            endcase
        end
    end

    // A new engine error wins over a same-cycle W1C, but only lands on a clean field.
    always_comb begin
        w_sberror_nxt = r_sberror;
        if (w_sbcs_wr)
            w_sberror_nxt = r_sberror & ~dmi_data_i[SBCS_ERROR_LSB +: 3];
        if ((r_sberror == 3'd0) && (sberror_i != 3'd0))
            w_sberror_nxt = sberror_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_rdata;
        end else if (r_resp_valid && dmi_resp_ready_i) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbbusyerror <= 1'b0;
            r_sberror     <= '0;
            r_readonaddr  <= 1'b0;
            r_autoinc     <= 1'b0;
            r_readondata  <= 1'b0;
            r_access      <= 3'd2;
            r_sbaddress   <= '0;
            r_sbdata      <= '0;
            r_addr_wr_pls <= 1'b0;
            r_data_wr_pls <= 1'b0;
            r_data_rd_pls <= 1'b0;
            r_last_read   <= 1'b0;
        end else begin
            r_addr_wr_pls <= 1'b0;
            r_data_wr_pls <= 1'b0;
            r_data_rd_pls <= 1'b0;
            r_sberror     <= w_sberror_nxt;
            if (w_sbcs_wr) begin
                r_readonaddr <= dmi_data_i[SBCS_READONADDR];
                r_access     <= dmi_data_i[SBCS_ACCESS_LSB +: 3];
                r_autoinc    <= dmi_data_i[SBCS_AUTOINC];
                r_readondata <= dmi_data_i[SBCS_READONDATA];
                if (dmi_data_i[SBCS_BUSYERROR])
                    r_sbbusyerror <= 1'b0;
            end
            if (w_busy_hit)
                r_sbbusyerror <= 1'b1;
            // r_last_read remembers whether the access just launched is a bus read.
            if (w_addr_wr && !w_blocked) begin
                r_sbaddress   <= dmi_data_i;
                r_addr_wr_pls <= 1'b1;
                if (r_readonaddr)
                    r_last_read <= 1'b1;
            end
            if (w_data_wr && !w_blocked) begin
                r_sbdata      <= dmi_data_i;
                r_data_wr_pls <= 1'b1;
                r_last_read   <= 1'b0;
            end
            if (w_data_rd && !w_blocked) begin
                r_data_rd_pls <= 1'b1;
                if (r_readondata)
                    r_last_read <= 1'b1;
            end
            if (sbdata_valid_i) begin
                r_sbaddress <= sbaddress_i;
                if (r_last_read)
                    r_sbdata <= sbdata_i;
            end
        end
    end

    assign dmi_req_ready_o         = r_req_ready;
    assign dmi_resp_valid_o        = r_resp_valid;
    assign dmi_resp_data_o         = r_resp_data;
    assign sbaddress_o             = r_sbaddress;
    assign sbaddress_write_valid_o = r_addr_wr_pls;
    assign sbreadonaddr_o          = r_readonaddr;
    assign sbautoincrement_o       = r_autoinc;
    assign sbaccess_o              = r_access;
    assign sbreadondata_o          = r_readondata;
    assign sbdata_o                = r_sbdata;
    assign sbdata_read_valid_o     = r_data_rd_pls;
    assign sbdata_write_valid_o    = r_data_wr_pls;

endmodule

// File: tb/tb_jtag_sb_csr.sv
// Bench for jtag_sb_csr: directed vector table, hand-written corner sequences,
// then randomized traffic against an architectural reference model.
module tb_jtag_sb_csr;
    import jtag_dm_pkg::*;

    localparam int SBASIZE   = 32;
    localparam int SBVERSION = 1;
    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmi_req_valid = 1'b0;
    logic        dmi_req_ready;
    logic [6:0]  dmi_addr = '0;
    logic [1:0]  dmi_op = '0;
    logic [31:0] dmi_data = '0;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready = 1'b1;
    logic [31:0] dmi_resp_data;
    logic [31:0] sbaddress_o;
    logic        sbaddress_write_valid;
    logic        sbreadonaddr;
    logic        sbautoincrement;
    logic [2:0]  sbaccess;
    logic        sbreadondata;
    logic [31:0] sbdata_o;
    logic        sbdata_read_valid;
    logic        sbdata_write_valid;
    logic [31:0] sbaddress_i = '0;
    logic [31:0] sbdata_i = '0;
    logic        sbdata_valid = 1'b0;
    logic        sbbusy = 1'b0;
    logic [2:0]  sberror = '0;

    int n_chk = 0;
    int n_err = 0;

    jtag_sb_csr #(.SBASIZE(SBASIZE), .SBVERSION(SBVERSION)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmi_req_valid_i(dmi_req_valid), .dmi_req_ready_o(dmi_req_ready),
        .dmi_addr_i(dmi_addr), .dmi_op_i(dmi_op), .dmi_data_i(dmi_data),
        .dmi_resp_valid_o(dmi_resp_valid), .dmi_resp_ready_i(dmi_resp_ready),
        .dmi_resp_data_o(dmi_resp_data),
        .sbaddress_o(sbaddress_o), .sbaddress_write_valid_o(sbaddress_write_valid),
        .sbreadonaddr_o(sbreadonaddr), .sbautoincrement_o(sbautoincrement),
        .sbaccess_o(sbaccess), .sbreadondata_o(sbreadondata),
        .sbdata_o(sbdata_o), .sbdata_read_valid_o(sbdata_read_valid),
        .sbdata_write_valid_o(sbdata_write_valid),
        .sbaddress_i(sbaddress_i), .sbdata_i(sbdata_i), .sbdata_valid_i(sbdata_valid),
        .sbbusy_i(sbbusy), .sberror_i(sberror)
    );

    always #5 clk = ~clk;

    // reference model of the architectural sb* state
    logic        m_busyerr, m_roa, m_autoinc, m_rod, m_last_read;
    logic [2:0]  m_access, m_err;
    logic [31:0] m_addr, m_data;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic        busy;
        logic        cpl;
        logic [31:0] exp_rd;
        logic [2:0]  exp_pls;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] pulses();
        return {sbaddress_write_valid, sbdata_write_valid, sbdata_read_valid};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!dmi_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", 32'(dmi_req_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd);
        wait_ready();
        dmi_req_valid = 1'b1; dmi_op = op; dmi_addr = addr; dmi_data = wd;
        @(posedge clk); #1;
        dmi_req_valid = 1'b0; dmi_op = NOP;
    endtask

    task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic [2:0] pls);
        dmi_resp_ready = 1'b1;
        issue(op, addr, wd);
        chk("resp_valid", 32'(dmi_resp_valid), 32'd1);
        rd  = dmi_resp_data;
        pls = pulses();
        @(posedge clk); #1;
        chk("pulse_width", 32'(pulses()), 32'd0);
        chk("resp_drop", 32'(dmi_resp_valid), 32'd0);
    endtask

    task automatic eng_cpl(input logic [31:0] a, input logic [31:0] d);
        sbdata_valid = 1'b1; sbaddress_i = a; sbdata_i = d;
        @(posedge clk); #1;
        sbdata_valid = 1'b0;
    endtask

    task automatic eng_err(input logic [2:0] e);
        sberror = e;
        @(posedge clk); #1;
        sberror = '0;
    endtask

    function automatic logic [31:0] m_sbcs(input logic busy);
        return 32'(SBVERSION) * 32'h2000_0000 + (m_busyerr ? 32'h40_0000 : 0) +
               (busy ? 32'h20_0000 : 0) + (m_roa ? 32'h10_0000 : 0) +
               32'(m_access) * 32'h2_0000 + (m_autoinc ? 32'h1_0000 : 0) +
               (m_rod ? 32'h8000 : 0) + 32'(m_err) * 32'h1000 + 32'(SBASIZE) * 32 + 7;
    endfunction

    task automatic model_reset();
        m_busyerr = 0; m_roa = 0; m_autoinc = 0; m_rod = 0; m_last_read = 0;
        m_access = 3'd2; m_err = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                              input logic busy, output logic [31:0] rd, output logic [2:0] pls);
        logic blocked;
        blocked = busy || m_busyerr || (m_err != 0);
        rd = 0; pls = 0;
        if (op == RD) begin
            if (addr == DM_SBCS) rd = m_sbcs(busy);
            else if (addr == DM_SBADDRESS0) rd = m_addr;
            else if (addr == DM_SBDATA0) begin
                rd = m_data;
                if (busy) m_busyerr = 1;
                else if (!blocked) begin
                    pls = 3'b001;
                    if (m_rod) m_last_read = 1;
                end
            end
        end else if (op == WR) begin
            if (addr == DM_SBCS) begin
                m_roa = wd[20]; m_access = wd[19:17]; m_autoinc = wd[16]; m_rod = wd[15];
                if (wd[22]) m_busyerr = 0;
                m_err = m_err & ~wd[14:12];
            end else if (addr == DM_SBADDRESS0) begin
                if (busy) m_busyerr = 1;
                else if (!blocked) begin
                    m_addr = wd; pls = 3'b100;
                    if (m_roa) m_last_read = 1;
                end
            end else if (addr == DM_SBDATA0) begin
                if (busy) m_busyerr = 1;
                else if (!blocked) begin
                    m_data = wd; pls = 3'b010; m_last_read = 0;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rd, exp_rd, d0;
        logic [2:0]  pls, exp_pls;

        tbl[0]  = '{RD, DM_SBCS,       32'h0,          1'b0, 1'b0, 32'h20040407, 3'b000, 32'h0};
        tbl[1]  = '{WR, DM_SBCS,       32'h0015_0000,  1'b0, 1'b0, 32'h0,        3'b000, 32'h0};
        tbl[2]  = '{RD, DM_SBCS,       32'h0,          1'b0, 1'b0, 32'h20150407, 3'b000, 32'h0};
        tbl[3]  = '{WR, DM_SBADDRESS0, 32'h1000,       1'b0, 1'b0, 32'h0,        3'b100, 32'h1000};
        tbl[4]  = '{RD, DM_SBDATA0,    32'h0,          1'b0, 1'b1, 32'hDEADBEEF, 3'b001, 32'h1004};
        tbl[5]  = '{RD, 7'h10,         32'h0,          1'b0, 1'b0, 32'h0,        3'b000, 32'h1004};
        tbl[6]  = '{NOP, DM_SBCS,      32'hFFFF_FFFF,  1'b0, 1'b0, 32'h0,        3'b000, 32'h1004};
        tbl[7]  = '{WR, DM_SBDATA0,    32'h55,         1'b1, 1'b0, 32'h0,        3'b000, 32'h1004};
        tbl[8]  = '{RD, DM_SBCS,       32'h0,          1'b0, 1'b0, 32'h20550407, 3'b000, 32'h1004};
        tbl[9]  = '{WR, DM_SBDATA0,    32'h66,         1'b0, 1'b0, 32'h0,        3'b000, 32'h1004};
        tbl[10] = '{RD, DM_SBDATA0,    32'h0,          1'b0, 1'b0, 32'hDEADBEEF, 3'b000, 32'h1004};
        tbl[11] = '{WR, DM_SBCS,       32'h0055_0000,  1'b0, 1'b0, 32'h0,        3'b000, 32'h1004};
        tbl[12] = '{RD, DM_SBCS,       32'h0,          1'b0, 1'b0, 32'h20150407, 3'b000, 32'h1004};
        tbl[13] = '{WR, DM_SBDATA0,    32'h12345678,   1'b0, 1'b0, 32'h0,        3'b010, 32'h1004};
        tbl[14] = '{RD, DM_SBDATA0,    32'h0,          1'b0, 1'b0, 32'h12345678, 3'b001, 32'h1004};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", 32'(dmi_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
        chk("rst_sbaccess", 32'(sbaccess), 32'd2);
        chk("rst_flags", {27'd0, sbreadonaddr, sbautoincrement, sbreadondata, 2'b0}, 32'd0);
        chk("rst_pulses", 32'(pulses()), 32'd0);
        chk("rst_sbaddress", sbaddress_o, 32'd0);
        chk("rst_sbdata", sbdata_o, 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].cpl) eng_cpl(32'h1004, 32'hDEADBEEF);
            sbbusy = tbl[i].busy;
            dmi_xfer(tbl[i].op, tbl[i].addr, tbl[i].wd, rd, pls);
            sbbusy = 1'b0;
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_pulse", i), 32'(pls), 32'(tbl[i].exp_pls));
            chk($sformatf("tbl%0d_sbaddr", i), sbaddress_o, tbl[i].exp_addr);
        end
        chk("tbl_sbcs_fields", {26'd0, sbreadonaddr, sbaccess, sbautoincrement, sbreadondata},
            32'b10101_0);

        // sticky engine error and per-bit W1C
        eng_err(3'd3);
        dmi_xfer(RD, DM_SBCS, 0, rd, pls);
        chk("err_latched", rd, 32'h20153407);
        eng_err(3'd4);
        dmi_xfer(RD, DM_SBCS, 0, rd, pls);
        chk("err_sticky", rd, 32'h20153407);
        dmi_xfer(WR, DM_SBADDRESS0, 32'h2000, rd, pls);
        chk("err_blk_pulse", 32'(pls), 32'd0);
        chk("err_blk_addr", sbaddress_o, 32'h1004);
        dmi_xfer(WR, DM_SBCS, 32'h0015_1000, rd, pls);
        dmi_xfer(RD, DM_SBCS, 0, rd, pls);
        chk("err_w1c_bit", rd, 32'h20152407);
        dmi_xfer(WR, DM_SBCS, 32'h0015_7000, rd, pls);
        dmi_xfer(RD, DM_SBCS, 0, rd, pls);
        chk("err_w1c_all", rd, 32'h20150407);
        dmi_xfer(WR, DM_SBADDRESS0, 32'h2000, rd, pls);
        chk("err_clr_pulse", 32'(pls), 32'b100);
        chk("err_clr_addr", sbaddress_o, 32'h2000);

        // response back-pressure
        dmi_resp_ready = 1'b0;
        issue(RD, DM_SBDATA0, 0);
        d0 = dmi_resp_data;
        chk("bp_first_data", d0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(dmi_resp_valid), 32'd1);
            chk("bp_data", dmi_resp_data, d0);
            chk("bp_req_ready", 32'(dmi_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        dmi_resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_taken_valid", 32'(dmi_resp_valid), 32'd0);
        chk("bp_taken_ready", 32'(dmi_req_ready), 32'd1);

        // async reset while a response and a pulse are pending
        dmi_resp_ready = 1'b0;
        issue(WR, DM_SBADDRESS0, 32'h3000);
        chk("mid_pulse", 32'(pulses()), 32'b100);
        chk("mid_valid", 32'(dmi_resp_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dmi_resp_valid), 32'd0);
        chk("arst_sbaccess", 32'(sbaccess), 32'd2);
        chk("arst_pulses", 32'(pulses()), 32'd0);
        chk("arst_sbaddr", sbaddress_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmi_resp_ready = 1'b1;
        model_reset();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0]  op;
            logic [6:0]  addr;
            logic [31:0] wd, a, d;
            logic        busy;
            logic [2:0]  e;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = $urandom(); d = $urandom();
                eng_cpl(a, d);
                m_addr = a;
                if (m_last_read) m_data = d;
            end else if (r == 1) begin
                e = 3'($urandom_range(1, 7));
                eng_err(e);
                if (m_err == 0) m_err = e;
            end else begin
                op = 2'($urandom_range(0, 2));
                case ($urandom_range(0, 3))
                    0: addr = DM_SBCS;
                    1: addr = DM_SBADDRESS0;
                    2: addr = DM_SBDATA0;
                    default: addr = 7'($urandom());
                endcase
                wd = $urandom();
                if (addr == DM_SBCS && $urandom_range(0, 2) != 0) wd = wd | 32'h0040_7000;
                busy = ($urandom_range(0, 3) == 0);
                sbbusy = busy;
                dmi_xfer(op, addr, wd, rd, pls);
                sbbusy = 1'b0;
                model_xfer(op, addr, wd, busy, exp_rd, exp_pls);
                chk("rnd_rdata", rd, exp_rd);
                chk("rnd_pulse", 32'(pls), 32'(exp_pls));
            end
            chk("rnd_sbaddr", sbaddress_o, m_addr);
            chk("rnd_sbdata", sbdata_o, m_data);
            chk("rnd_fields", {26'd0, sbreadonaddr, sbaccess, sbautoincrement, sbreadondata},
                {26'd0, m_roa, m_access, m_autoinc, m_rod});
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
